// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, legality check and FSM encoding
// shared by the ALU arbiter slice
package alu_pkg;

  localparam int unsigned OP_ARITH_LO = 1;
  localparam int unsigned OP_ARITH_HI = 5;
  localparam int unsigned OP_SHIFT_LO = 8;
  localparam int unsigned OP_SHIFT_HI = 16;
  localparam int unsigned OP_MUL_LO   = 24;
  localparam int unsigned OP_MUL_HI   = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [31:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op >= OP_ARITH_LO && op <= OP_ARITH_HI): ok = 1'b1;
      (op >= OP_SHIFT_LO && op <= OP_SHIFT_HI): ok = 1'b1;
      (op >= OP_MUL_LO && op <= OP_MUL_HI):     ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; priority
// moves to the other requester when a service completes
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_id_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic prio_q;
  logic prio_d;

  // favour the requester that was not served last
  always_comb begin
    prio_d = prio_q;
    if (upd_i) prio_d = ~upd_id_i;
  end

  // priority register, req0 favoured out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  // lone requester wins, ties go to the favoured one
  always_comb begin
    gnt0_o = req0_i & (~req1_i | ~prio_q);
    gnt1_o = req1_i & (~req0_i | prio_q);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: serves two requesters one ALU op at a
// time with round-robin grant and a response timeout
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_valid
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e           st_q, st_d;
  logic             own_q, own_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             gnt0, gnt1;
  logic             in_idle;
  logic             acc0, acc1, acc;
  logic             rsp_take;
  logic [OP_W-1:0]  acc_op;

  assign in_idle  = (st_q == ST_IDLE);
  assign acc0     = req0_valid & req0_ready;
  assign acc1     = req1_valid & req1_ready;
  assign acc      = acc0 | acc1;
  assign acc_op   = acc1 ? req1_op : req0_op;
  assign rsp_take = (st_q == ST_RESP) &
                    (own_q ? rsp1_ready : rsp0_ready);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .upd_i    (rsp_take),
    .upd_id_i (own_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  assign req0_ready = in_idle & gnt0;
  assign req1_ready = in_idle & gnt1;

  assign alu_en = (st_q == ST_ISSUE);
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  assign rsp0_valid = (st_q == ST_RESP) & ~own_q;
  assign rsp1_valid = (st_q == ST_RESP) & own_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

  // next state, captured request and response
  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    data_d = data_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (acc) begin
          own_d = acc1;
          op_d  = acc_op;
          a_d   = acc1 ? req1_a : req0_a;
          b_d   = acc1 ? req1_b : req0_b;
          if (op_legal(32'(acc_op))) begin
            st_d = ST_ISSUE;
          end else begin
            st_d   = ST_RESP;
            data_d = '0;
            err_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        st_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (alu_valid) begin
          data_d = alu_data;
          err_d  = 1'b0;
          st_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d = '0;
          err_d  = 1'b1;
          st_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_take) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      own_q  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random
// traffic against a transaction-timing reference model
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int OW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic          alu_en;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_a, alu_b;
  logic [W-1:0]  alu_data;
  logic          alu_valid;

  int errs   = 0;
  int checks = 0;

  longint cyc = 0;

  // reference model: one outstanding transaction
  bit            m_busy = 0;
  bit            m_prio = 0;
  bit            m_own  = 0;
  bit            m_leg  = 0;
  bit            m_wh   = 0;
  longint        m_t    = 0;
  logic [OW-1:0] m_op   = '0;
  logic [W-1:0]  m_a    = '0;
  logic [W-1:0]  m_b    = '0;

  int  wh_mode = 1;
  bit  spur_en = 0;
  bit  spur    = 0;
  int  own_log[$];

  alu_arbiter #(
    .WIDTH   (W),
    .OP_W    (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_data   (alu_data),
    .alu_valid  (alu_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [OW-1:0] op,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b
  );
    if (op == 5'd1) return a + b;
    if (op == 5'd2) return a - b;
    return (a ^ {b[15:0], b[31:16]}) + 32'(op);
  endfunction

  function automatic bit legal(input int op);
    return (op >= 1 && op <= 5) ||
           (op >= 8 && op <= 16) ||
           (op >= 24 && op <= 27);
  endfunction

  // ALU with one-cycle registered latency
  always @(posedge clk) begin
    alu_valid <= (alu_en && !m_wh) || spur;
    alu_data  <= alu_en ? alu_f(alu_op, alu_a, alu_b)
                        : $urandom;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit     idle, e0, e1, win, en;
    longint lat;
    #1;
    idle = !m_busy;
    e0   = idle && req0_valid && (!req1_valid || !m_prio);
    e1   = idle && req1_valid && (!req0_valid || m_prio);
    lat  = !m_leg ? 1 : (m_wh ? 2 + TO : 3);
    win  = m_busy && (cyc >= m_t + lat);
    en   = m_busy && m_leg && (cyc == m_t + 1);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp0_valid", rsp0_valid, win && !m_own);
    chk("rsp1_valid", rsp1_valid, win && m_own);
    chk("alu_en", alu_en, en);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (win) begin
      chk("rsp_data", rsp_data,
          (m_leg && !m_wh) ? alu_f(m_op, m_a, m_b) : '0);
      chk("rsp_err", rsp_err, !m_leg || m_wh);
    end
    if (req0_valid && req0_ready) own_log.push_back(0);
    if (req1_valid && req1_ready) own_log.push_back(1);
    if (win && (m_own ? rsp1_ready : rsp0_ready)) begin
      m_busy = 0;
      m_prio = !m_own;
    end else if (e0 || e1) begin
      m_busy = 1;
      m_own  = e1;
      m_t    = cyc;
      m_op   = e1 ? req1_op : req0_op;
      m_a    = e1 ? req1_a : req0_a;
      m_b    = e1 ? req1_b : req0_b;
      m_leg  = legal(int'(m_op));
      case (wh_mode)
        1:       m_wh = 0;
        2:       m_wh = m_leg;
        default: m_wh = m_leg && ($urandom_range(0, 7) == 0);
      endcase
    end
    spur = spur_en && !(m_busy && m_wh) &&
           ($urandom_range(0, 3) == 0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // asynchronous reset, checked right after assertion
  task automatic do_reset();
    rst  = 1'b1;
    spur = 0;
    #1;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rdy0", req0_ready, req0_valid);
    chk("rst_rdy1", req1_ready, req1_valid && !req0_valid);
    m_busy = 0;
    m_prio = 0;
    m_wh   = 0;
    m_op   = '0;
    m_a    = '0;
    m_b    = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rsp0_valid || rsp1_valid) return;
      step();
      n++;
    end
    chk("rsp_timeout", 0, 1);
  endtask

  task automatic idle_in();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_in();
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0;
    req1_a = '0; req1_b = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    do_reset();

    // lone req0, ADD 5+7
    wh_mode = 1;
    req0_valid = 1; req0_op = 5'd1;
    req0_a = 32'd5; req0_b = 32'd7;
    step();
    req0_valid = 0;
    #1;
    chk("d1_alu_en", alu_en, 1);
    chk("d1_alu_a", alu_a, 5);
    chk("d1_alu_b", alu_b, 7);
    step();
    step();
    #1;
    chk("d1_rsp0_valid", rsp0_valid, 1);
    chk("d1_rsp_data", rsp_data, 12);
    chk("d1_rsp_err", rsp_err, 0);
    step();
    step();

    // both requesting from reset: alternate
    do_reset();
    own_log.delete();
    req0_valid = 1; req0_op = 5'd1;
    req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1; req1_op = 5'd2;
    req1_a = 32'd50; req1_b = 32'd8;
    for (int i = 0; i < 40 && own_log.size() < 4; i++)
      step();
    chk("rr_count", own_log.size(), 4);
    if (own_log.size() >= 4) begin
      chk("rr_first", own_log[0], 0);
      chk("rr_second", own_log[1], 1);
      chk("rr_third", own_log[2], 0);
      chk("rr_fourth", own_log[3], 1);
    end
    idle_in();
    for (int i = 0; i < 6; i++) step();

    // illegal op from req1
    req1_valid = 1; req1_op = 5'd6;
    req1_a = 32'hdead; req1_b = 32'hbeef;
    step();
    req1_valid = 0;
    #1;
    chk("ill_alu_en", alu_en, 0);
    chk("ill_rsp1_valid", rsp1_valid, 1);
    chk("ill_rsp_err", rsp_err, 1);
    chk("ill_rsp_data", rsp_data, 0);
    step();
    step();

    // ALU never answers: timeout
    wh_mode = 2;
    req0_valid = 1; req0_op = 5'd2;
    req0_a = 32'd9; req0_b = 32'd3;
    step();
    req0_valid = 0;
    wait_rsp(n);
    chk("to_latency", n, 2 + TO);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    step();
    step();

    // back-pressure on rsp0 with req1 waiting
    wh_mode = 1;
    do_reset();
    rsp0_ready = 0;
    req0_valid = 1; req0_op = 5'd3;
    req0_a = 32'h1234; req0_b = 32'h55;
    req1_valid = 1; req1_op = 5'd9;
    req1_a = 32'h77; req1_b = 32'h2;
    step();
    req0_valid = 0;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    step();
    #1;
    chk("bp_req1_grant", req1_ready, 1);
    step();
    req1_valid = 0;
    for (int i = 0; i < 5; i++) step();

    // reset during WAIT abandons the op
    wh_mode = 2;
    req0_valid = 1; req0_op = 5'd4;
    req0_a = 32'hf0; req0_b = 32'h0f;
    step();
    req0_valid = 0;
    step();
    step();
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    req0_valid = 1; req1_valid = 1;
    req0_op = 5'd8; req1_op = 5'd10;
    #1;
    chk("pr_grant0", req0_ready, 1);
    chk("pr_grant1", req1_ready, 0);
    step();
    idle_in();
    for (int i = 0; i < 15; i++) step();

    // random traffic
    wh_mode = 0;
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || $urandom_range(0, 3) == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 5'($urandom);
        req0_a = $urandom;
        req0_b = $urandom;
      end
      if (!req1_valid || $urandom_range(0, 3) == 0) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 5'($urandom);
        req1_a = $urandom;
        req1_b = $urandom;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
